io_bank_wb: RTL and testbench
=============================

IO_BANK_WB -- requirements
Module: io_bank_wb

Interface
REQ-001 The block SHALL have parameter NUM_IO, default 38, the number of IO channels (legal 1..64).
REQ-002 The block SHALL have parameter NUM_IRQ, default 3, the number of user_irq lines (legal 1..8).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, the Wishbone window base; bits [7:0] are ignored.
REQ-004 The port list SHALL begin: wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 wb_rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write enable.
REQ-007 wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data; wbs_sel_i  in  4  byte lanes.
REQ-008 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-009 io_in  in  NUM_IO  pad inputs, asynchronous to wb_clk_i.
REQ-010 io_out  out  NUM_IO  pad output values; io_oeb  out  NUM_IO  output enable, active-low.
REQ-011 user_irq  out  NUM_IRQ  level interrupts to the management core.

Function
REQ-012 Hit SHALL be cyc&stb&(wbs_adr_i[31:8]==BASE_ADDR[31:8]); non-hits SHALL never be acked.
REQ-013 Register map (offset wbs_adr_i[7:0]): 0x00/0x04 OUT lo/hi RW; 0x08/0x0C OEB lo/hi RW; 0x10/0x14 IN lo/hi RO; 0x18/0x1C IRQ_EN lo/hi RW; 0x20/0x24 IRQ_STS lo/hi W1C; 0x28/0x2C EDGE_POL lo/hi RW (0 rising, 1 falling); lo = channels 31:0, hi = 63:32.
REQ-014 Handshake: wbs_ack_o SHALL pulse high exactly one cycle, in the cycle after a hit with wbs_ack_o low; a hit while ack is high SHALL not produce a second ack that cycle (max one ack per two cycles).
REQ-015 Writes SHALL take effect on the ack edge, per byte lane enabled by wbs_sel_i; read data SHALL be registered and valid only while ack is high, else wbs_dat_o = 0.
REQ-016 Bits for channels >= NUM_IO SHALL read 0 and ignore writes; unmapped offsets in the window SHALL read 0, ignore writes, and still ack.
REQ-017 io_in SHALL pass a 2-flop synchronizer; IN reads synchronized values (latency 2 cycles from pad change).
REQ-018 An edge SHALL be the synchronized value vs its one-cycle-delayed copy, polarity per EDGE_POL; a detected edge sets IRQ_STS[i] the next cycle regardless of IRQ_EN.
REQ-019 Writing 1 to an IRQ_STS bit SHALL clear it; if an edge sets the same bit in the same cycle, set SHALL win.
REQ-020 user_irq[k] SHALL be registered OR over i with i mod NUM_IRQ == k of IRQ_STS[i]&IRQ_EN[i].
REQ-021 io_out = OUT and io_oeb = OEB directly from registers, no combinational path from Wishbone inputs.
REQ-022 Changing EDGE_POL SHALL not itself generate an edge.

Reset
REQ-023 Asserting wb_rst_ni low SHALL immediately force: wbs_ack_o 0, wbs_dat_o 0, OUT 0, OEB all ones, IRQ_EN 0, IRQ_STS 0, EDGE_POL 0, user_irq 0, synchronizer and delay flops 0.
REQ-024 Reset during a pending transfer SHALL abort it with no ack and no register update; first hit after deassertion is acked normally.
REQ-025 Delay flops reset to 0 SHALL not cause a spurious rising edge: edge detection SHALL be suppressed for the first 3 cycles after reset release.

Structure
REQ-026 Register offsets, offset width and the max channel count 64 SHALL live in shared package io_bank_pkg.
REQ-027 One sub-module io_bank_sync_edge (synchronizer, delay, polarity edge detect, per-channel vector) SHALL be used; all else in io_bank_wb.

Verification
REQ-028 Reset, then read OEB_LO -> 0xFFFF_FFFF; OEB_HI -> 0x0000_003F; ack exactly one cycle after strobe.
REQ-029 Write OUT_LO 0xA5A5_A5A5 with sel=4'b0011 -> io_out[31:0]=0x0000_A5A5 after ack; readback matches.
REQ-030 IRQ_EN_LO=0x1; io_in[0] 0->1 -> IRQ_STS_LO bit0=1 within 4 cycles, user_irq[0]=1; write 1 to IRQ_STS_LO bit0 -> user_irq[0]=0.
REQ-031 EDGE_POL_HI bit5=1, IRQ_EN_HI bit5=1; io_in[37] 1->0 -> user_irq[37 mod 3=1]=1; rising edge on io_in[37] -> no set.
REQ-032 Edge on channel 3 in same cycle as W1C of bit 3 -> IRQ_STS bit3 remains 1.
REQ-033 Access to 0x3000_0100 -> no ack; access to 0x3000_00F0 -> ack, read 0; reset asserted mid-strobe -> no ack, registers at reset values.

Source files
------------

// File: rtl/io_bank_pkg.sv
// IO bank register map and shared decode helpers.
// Offsets are byte addresses within the 256-byte Wishbone window.
package io_bank_pkg;

  localparam int MAX_IO = 64;
  localparam int OFS_W  = 8;

  localparam logic [OFS_W-1:0] OFS_OUT_LO = 8'h00;
  localparam logic [OFS_W-1:0] OFS_OUT_HI = 8'h04;
  localparam logic [OFS_W-1:0] OFS_OEB_LO = 8'h08;
  localparam logic [OFS_W-1:0] OFS_OEB_HI = 8'h0C;
  localparam logic [OFS_W-1:0] OFS_IN_LO  = 8'h10;
  localparam logic [OFS_W-1:0] OFS_IN_HI  = 8'h14;
  localparam logic [OFS_W-1:0] OFS_IEN_LO = 8'h18;
  localparam logic [OFS_W-1:0] OFS_IEN_HI = 8'h1C;
  localparam logic [OFS_W-1:0] OFS_STS_LO = 8'h20;
  localparam logic [OFS_W-1:0] OFS_STS_HI = 8'h24;
  localparam logic [OFS_W-1:0] OFS_POL_LO = 8'h28;
  localparam logic [OFS_W-1:0] OFS_POL_HI = 8'h2C;

  typedef enum logic [2:0] {
    REG_OUT,
    REG_OEB,
    REG_IN,
    REG_IEN,
    REG_STS,
    REG_POL,
    REG_NONE
  } reg_e;

  function automatic reg_e reg_decode(
    input logic [OFS_W-1:0] ofs
  );
    reg_e r;
    unique case (ofs)
      OFS_OUT_LO, OFS_OUT_HI: r = REG_OUT;
      OFS_OEB_LO, OFS_OEB_HI: r = REG_OEB;
      OFS_IN_LO,  OFS_IN_HI:  r = REG_IN;
      OFS_IEN_LO, OFS_IEN_HI: r = REG_IEN;
      OFS_STS_LO, OFS_STS_HI: r = REG_STS;
      OFS_POL_LO, OFS_POL_HI: r = REG_POL;
      default:                r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/io_bank_sync_edge.sv
// Per-channel pad synchronizer with polarity-selectable edge detect.
// Edges are held off for three cycles after reset release.
module io_bank_sync_edge #(
  parameter int N = 38
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_pad,
  input  logic [N-1:0] i_pol,
  output logic [N-1:0] o_sync,
  output logic [N-1:0] o_edge
);

  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;
  logic [N-1:0] r_dly;
  logic [1:0]   r_arm_cnt;
  logic         w_armed;

  assign w_armed = (r_arm_cnt == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_dly     <= '0;
      r_arm_cnt <= 2'd0;
    end else begin
      r_s1  <= i_pad;
      r_s2  <= r_s1;
      r_dly <= r_s2;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  // Only a real transition can fire; flipping i_pol alone never does.
  assign o_sync = r_s2;
  assign o_edge = w_armed ?
    ((r_s2 ^ r_dly) & (r_s2 ^ i_pol)) : '0;

endmodule

// File: rtl/io_bank_wb.sv
// Wishbone-mapped GPIO bank with edge interrupts.
// Registers are NUM_IO wide; bits above NUM_IO read as zero.
module io_bank_wb
  import io_bank_pkg::*;
#(
  parameter int          NUM_IO    = 38,
  parameter int          NUM_IRQ   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [3:0]         wbs_sel_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [NUM_IO-1:0]  io_in,
  output logic [NUM_IO-1:0]  io_out,
  output logic [NUM_IO-1:0]  io_oeb,
  output logic [NUM_IRQ-1:0] user_irq
);

  logic               r_ack;
  logic [31:0]        r_dat;
  logic [NUM_IO-1:0]  r_out;
  logic [NUM_IO-1:0]  r_oeb;
  logic [NUM_IO-1:0]  r_ien;
  logic [NUM_IO-1:0]  r_sts;
  logic [NUM_IO-1:0]  r_pol;
  logic [NUM_IRQ-1:0] r_irq;

  logic               w_hit;
  logic               w_take;
  logic               w_wr;
  logic               w_hi;
  reg_e               w_reg;
  logic [NUM_IO-1:0]  w_sync;
  logic [NUM_IO-1:0]  w_edge;
  logic [NUM_IO-1:0]  w_lane;
  logic [NUM_IO-1:0]  w_wbit;
  logic [NUM_IO-1:0]  w_wm_out;
  logic [NUM_IO-1:0]  w_wm_oeb;
  logic [NUM_IO-1:0]  w_wm_ien;
  logic [NUM_IO-1:0]  w_wm_pol;
  logic [NUM_IO-1:0]  w_clr;
  logic [NUM_IO-1:0]  w_rvec;
  logic [31:0]        w_rd;
  logic [NUM_IRQ-1:0] w_irq;

  io_bank_sync_edge #(
    .N (NUM_IO)
  ) u_sync_edge (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_pad   (io_in),
    .i_pol   (r_pol),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  assign w_hit = wbs_cyc_i & wbs_stb_i &
    (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // Ack high blocks a second take, giving at most one ack per two cycles.
  assign w_take = w_hit & ~r_ack;
  assign w_wr   = w_take & wbs_we_i;
  assign w_hi   = wbs_adr_i[2];
  assign w_reg  = reg_decode(wbs_adr_i[OFS_W-1:0]);

  always_comb begin
    w_lane = '0;
    w_wbit = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      w_lane[i] = (((i / 32) == 1) == w_hi) &&
        wbs_sel_i[(i % 32) / 8];
      w_wbit[i] = wbs_dat_i[i % 32];
    end
  end

  assign w_wm_out = (w_wr && w_reg == REG_OUT) ? w_lane : '0;
  assign w_wm_oeb = (w_wr && w_reg == REG_OEB) ? w_lane : '0;
  assign w_wm_ien = (w_wr && w_reg == REG_IEN) ? w_lane : '0;
  assign w_wm_pol = (w_wr && w_reg == REG_POL) ? w_lane : '0;
  assign w_clr    = (w_wr && w_reg == REG_STS) ?
    (w_lane & w_wbit) : '0;

  always_comb begin
    w_rvec = '0;
    unique case (1'b1)
      w_reg == REG_OUT: w_rvec = r_out;
      w_reg == REG_OEB: w_rvec = r_oeb;
      w_reg == REG_IN:  w_rvec = w_sync;
      w_reg == REG_IEN: w_rvec = r_ien;
      w_reg == REG_STS: w_rvec = r_sts;
      w_reg == REG_POL: w_rvec = r_pol;
      default:          w_rvec = '0;
    endcase
    w_rd = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (((i / 32) == 1) == w_hi) w_rd[i % 32] = w_rvec[i];
    end
  end

  always_comb begin
    w_irq = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if ((i % NUM_IRQ) == k)
          w_irq[k] = w_irq[k] | (r_sts[i] & r_ien[i]);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
      r_out <= '0;
      r_oeb <= '1;
      r_ien <= '0;
      r_sts <= '0;
      r_pol <= '0;
      r_irq <= '0;
    end else begin
      r_ack <= w_take;
      r_dat <= (w_take && !wbs_we_i) ? w_rd : 32'h0;
      r_out <= (r_out & ~w_wm_out) | (w_wbit & w_wm_out);
      r_oeb <= (r_oeb & ~w_wm_oeb) | (w_wbit & w_wm_oeb);
      r_ien <= (r_ien & ~w_wm_ien) | (w_wbit & w_wm_ien);
      r_pol <= (r_pol & ~w_wm_pol) | (w_wbit & w_wm_pol);
      // A same-cycle edge wins over the clear.
      r_sts <= (r_sts & ~w_clr) | w_edge;
      r_irq <= w_irq;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_out;
  assign io_oeb    = r_oeb;
  assign user_irq  = r_irq;

endmodule

// File: tb/tb_io_bank_wb.sv
// Bench for io_bank_wb: directed scenarios plus random register
// traffic and pad toggles checked against a word-level model.
module tb_io_bank_wb;

  localparam int NIO  = 38;
  localparam int NIRQ = 3;
  localparam logic [63:0] CHM  = (64'd1 << NIO) - 64'd1;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cyc = 1'b0;
  logic            stb = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     adr = '0;
  logic [31:0]     wdat = '0;
  logic [3:0]      sel = '0;
  logic            ack;
  logic [31:0]     rdat;
  logic [NIO-1:0]  io_in = '0;
  logic [NIO-1:0]  io_out;
  logic [NIO-1:0]  io_oeb;
  logic [NIRQ-1:0] user_irq;

  always #5 clk = ~clk;

  io_bank_wb #(
    .NUM_IO    (NIO),
    .NUM_IRQ   (NIRQ),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_sel_i (sel),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .user_irq  (user_irq)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] m_out, m_oeb, m_en, m_sts, m_pol, m_pad;
  logic [31:0] rd;
  int          lat;

  task automatic m_reset();
    m_out = '0;
    m_oeb = CHM;
    m_en  = '0;
    m_sts = '0;
    m_pol = '0;
  endtask

  function automatic logic [63:0] m_merge(
    input logic [63:0] cur, input logic hi,
    input logic [31:0] d, input logic [3:0] s);
    logic [63:0] r;
    int base;
    r = cur;
    base = hi ? 32 : 0;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[base + b*8 +: 8] = d[b*8 +: 8];
    return r & CHM;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] ofs);
    logic [63:0] v;
    case (ofs)
      8'h00, 8'h04: v = m_out;
      8'h08, 8'h0C: v = m_oeb;
      8'h10, 8'h14: v = m_pad & CHM;
      8'h18, 8'h1C: v = m_en;
      8'h20, 8'h24: v = m_sts;
      8'h28, 8'h2C: v = m_pol;
      default:      v = '0;
    endcase
    return ofs[2] ? v[63:32] : v[31:0];
  endfunction

  function automatic logic [NIRQ-1:0] m_irq();
    logic [NIRQ-1:0] r;
    r = '0;
    for (int i = 0; i < NIO; i++)
      if (m_sts[i] && m_en[i]) r[i % NIRQ] = 1'b1;
    return r;
  endfunction

  task automatic wb(input logic w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] r, output int l);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = d; sel = s;
    l = 0; r = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (ack) begin l = c; r = rdat; break; end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] ofs,
                        input logic [31:0] d, input logic [3:0] s);
    wb(1'b1, BASE | {24'h0, ofs}, d, s, rd, lat);
    chk("wr_ack", 64'(lat), 64'd1);
    case (ofs)
      8'h00, 8'h04: m_out = m_merge(m_out, ofs[2], d, s);
      8'h08, 8'h0C: m_oeb = m_merge(m_oeb, ofs[2], d, s);
      8'h18, 8'h1C: m_en  = m_merge(m_en,  ofs[2], d, s);
      8'h28, 8'h2C: m_pol = m_merge(m_pol, ofs[2], d, s);
      8'h20, 8'h24: m_sts = m_sts & ~m_merge('0, ofs[2], d, s);
      default: ;
    endcase
  endtask

  task automatic reg_rd(input logic [7:0] ofs, input string tag);
    wb(1'b0, BASE | {24'h0, ofs}, '0, 4'hF, rd, lat);
    chk({tag, "_ack"}, 64'(lat), 64'd1);
    chk(tag, 64'(rd), 64'(m_read(ofs)));
  endtask

  task automatic set_pads(input logic [63:0] nv);
    logic [63:0] old;
    old = m_pad;
    @(negedge clk);
    m_pad = nv & CHM;
    io_in = m_pad[NIO-1:0];
    repeat (6) @(posedge clk);
    m_sts = m_sts | ((old ^ m_pad) & (m_pad ^ m_pol) & CHM);
  endtask

  task automatic check_outs(input string tag);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_out"}, 64'(io_out), m_out);
    chk({tag, "_oeb"}, 64'(io_oeb), m_oeb);
    chk({tag, "_irq"}, 64'(user_irq), 64'(m_irq()));
  endtask

  logic [7:0] ofs_tab [13] = '{8'h00, 8'h04, 8'h08, 8'h0C,
    8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30};

  initial begin
    int nack;
    logic [7:0] o;
    m_reset();
    m_pad = {$urandom, $urandom} & CHM;
    io_in = m_pad[NIO-1:0];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(rdat), 64'd0);
    chk("rst_oeb", 64'(io_oeb), CHM);
    chk("rst_irq", 64'(user_irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // Fresh reset: latency, OEB values, no spurious edges.
    wb(1'b0, BASE | 32'h08, '0, 4'hF, rd, lat);
    chk("oeb_lo_lat", 64'(lat), 64'd1);
    chk("oeb_lo", 64'(rd), 64'hFFFF_FFFF);
    reg_rd(8'h0C, "oeb_hi");
    chk("oeb_hi_val", 64'(rd), 64'h3F);
    reg_rd(8'h20, "sts_lo_rst");
    reg_rd(8'h24, "sts_hi_rst");
    reg_rd(8'h10, "in_lo");

    // Strobe held for 4 cycles yields acks on alternate cycles.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = BASE | 32'h08; sel = 4'hF;
    nack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) nack++;
    end
    chk("ack_rate", 64'(nack), 64'd2);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", 64'(ack), 64'd0);

    // Byte-lane write of OUT_LO.
    reg_wr(8'h00, 32'hA5A5_A5A5, 4'b0011);
    chk("out_lane", 64'(io_out[31:0]), 64'h0000_A5A5);
    reg_rd(8'h00, "out_lo_rb");

    // Rising edge on channel 0 raises user_irq[0]; W1C drops it.
    set_pads(m_pad & ~64'h1);
    reg_wr(8'h20, 32'hFFFF_FFFF, 4'hF);
    reg_wr(8'h24, 32'hFFFF_FFFF, 4'hF);
    reg_wr(8'h18, 32'h1, 4'hF);
    @(negedge clk);
    m_pad[0] = 1'b1;
    io_in = m_pad[NIO-1:0];
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (user_irq[0]) begin lat = c; break; end
    end
    chk("irq0_lat", 64'(lat), 64'd4);
    m_sts[0] = 1'b1;
    reg_rd(8'h20, "sts0_set");
    reg_wr(8'h20, 32'h1, 4'hF);
    check_outs("irq0_clr");

    // Falling-edge polarity on channel 37.
    set_pads(m_pad | (64'h1 << 37));
    reg_wr(8'h24, 32'hFFFF_FFFF, 4'hF);
    reg_wr(8'h2C, 32'h20, 4'hF);
    reg_wr(8'h1C, 32'h20, 4'hF);
    reg_rd(8'h24, "pol_nochg");
    set_pads(m_pad & ~(64'h1 << 37));
    check_outs("fall37");
    chk("irq1_fall", 64'(user_irq[1]), 64'd1);
    reg_wr(8'h24, 32'h20, 4'hF);
    set_pads(m_pad | (64'h1 << 37));
    reg_rd(8'h24, "rise37_none");
    check_outs("rise37");

    // Edge and W1C on channel 3 in the same cycle: set wins.
    set_pads(m_pad & ~64'h8);
    set_pads(m_pad | 64'h8);
    set_pads(m_pad & ~64'h8);
    reg_rd(8'h20, "sts3_pre");
    @(negedge clk);
    m_pad[3] = 1'b1;
    io_in = m_pad[NIO-1:0];
    @(posedge clk);
    @(posedge clk);
    wb(1'b1, BASE | 32'h20, 32'h8, 4'hF, rd, lat);
    chk("w1c3_ack", 64'(lat), 64'd1);
    m_sts[3] = 1'b1;
    repeat (3) @(posedge clk);
    reg_rd(8'h20, "sts3_setwins");

    // Outside window: no ack; unmapped offset inside: ack, zero.
    wb(1'b1, BASE | 32'h100, 32'hFFFF_FFFF, 4'hF, rd, lat);
    chk("miss_wr_ack", 64'(lat), 64'd0);
    wb(1'b0, BASE | 32'h100, '0, 4'hF, rd, lat);
    chk("miss_rd_ack", 64'(lat), 64'd0);
    reg_wr(8'hF0, 32'hFFFF_FFFF, 4'hF);
    reg_rd(8'hF0, "unmapped");
    reg_rd(8'h00, "out_after_miss");

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      o = ofs_tab[$urandom_range(0, 12)];
      case ($urandom_range(0, 3))
        0, 1: reg_wr(o, $urandom, 4'($urandom_range(0, 15)));
        2: reg_rd(o, "rnd_rd");
        default: set_pads(m_pad ^ ({$urandom, $urandom} & CHM));
      endcase
      if (it % 6 == 5) check_outs("rnd");
    end
    reg_rd(8'h20, "rnd_sts_lo");
    reg_rd(8'h24, "rnd_sts_hi");

    // Reset in the middle of a strobe.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = BASE; wdat = 32'h1234_5678; sel = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oeb", 64'(io_oeb), CHM);
    chk("arst_out", 64'(io_out), 64'd0);
    chk("arst_irq", 64'(user_irq), 64'd0);
    @(posedge clk); #1;
    chk("arst_ack", 64'(ack), 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    m_reset();
    repeat (8) @(posedge clk);
    reg_rd(8'h00, "post_rst_out");
    reg_rd(8'h0C, "post_rst_oeb");
    reg_rd(8'h20, "post_rst_sts");
    check_outs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
